// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 byte receiver: default timing, FSM state
// codes and the 3-sample majority helper.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int DEF_IDLE_BITS    = 20;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_byte_sync_vote.sv
// Line conditioning for the receiver: 2-FF synchroniser, one-cycle delayed
// copy for edge detection, and the three mid-bit samples reduced to a vote.
module uart_sync_vote
  import uart_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic uart_rxd,
  input  logic sample_first,  // cnt = HALF-1
  input  logic sample_mid,    // cnt = HALF
  output logic rxs,
  output logic fall,
  output logic vote
);

  logic meta;
  logic prev;
  logic samp_a;
  logic samp_b;

  // Synchronise the asynchronous line and keep the previous synchronised value.
  // NOTE: these flops reset to 1 (idle level) so leaving reset never looks
  // like a start edge; non-blocking assignments keep the chain a true shift.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= uart_rxd;
      rxs  <= meta;
      prev <= rxs;
    end
  end

  // Hold the first two of the three mid-bit samples.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (sample_first) samp_a <= rxs;
      if (sample_mid)   samp_b <= rxs;
    end
  end

  // The third sample is the live rxs, so vote is valid in the HALF+1 cycle.
  assign vote = maj3(samp_a, samp_b, rxs);
  assign fall = prev & ~rxs;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first byte receiver feeding the frame analyser. Rejects false
// starts by mid-bit majority vote, reports framing errors once per low
// episode, and pulses rx_idle after a quiet gap following a good byte.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic       rx_flag,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       rx_idle,
  output logic       rx_busy
);

  localparam int HALF       = CLKS_PER_BIT / 2;
  localparam int CW         = $clog2(CLKS_PER_BIT);
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int IW         = $clog2(IDLE_LIMIT + 1);

  localparam logic [CW-1:0] CNT_FIRST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(HALF);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_FIRE = IW'(IDLE_LIMIT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_LIMIT);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shift;
  logic [IW-1:0] idle_cnt;
  logic          idle_armed;

  logic rxs;
  logic fall;
  logic vote;
  logic in_frame;
  logic vote_now;
  logic wrap;

  assign in_frame = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
  assign vote_now = in_frame && (cnt == CNT_VOTE);
  assign wrap     = (cnt == CNT_LAST);
  assign rx_busy  = (state != ST_IDLE);

  uart_sync_vote u_sync_vote (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_rxd     (uart_rxd),
    .sample_first (in_frame && (cnt == CNT_FIRST)),
    .sample_mid   (in_frame && (cnt == CNT_MID)),
    .rxs          (rxs),
    .fall         (fall),
    .vote         (vote)
  );

  // Frame FSM: bit timing, data shifting and the flag/error pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bitidx  <= '0;
      shift   <= '0;
      rx_flag <= 1'b0;
      rx_err  <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_flag <= 1'b0;
      rx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt    <= '0;
          bitidx <= '0;
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (vote_now && vote) begin
            // Start bit did not hold through mid-bit: glitch, not a frame.
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (wrap) begin
            cnt    <= '0;
            bitidx <= '0;
            state  <= ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (vote_now) shift[bitidx] <= vote;
          if (wrap) begin
            cnt    <= '0;
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (vote_now) begin
            // Leave mid stop bit so the next start edge is never missed.
            cnt <= '0;
            if (vote) begin
              rx_data <= shift;
              rx_flag <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              rx_err <= 1'b1;
              state  <= ST_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          cnt <= '0;
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Idle-gap detector: armed by a good byte, fires once per gap, saturates.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b0;
      rx_idle    <= 1'b0;
    end else begin
      rx_idle <= 1'b0;
      if ((state == ST_IDLE) && fall) begin
        idle_cnt <= '0;
      end else if ((state == ST_STOP) && vote_now) begin
        // A good stop arms the detector; a framing error disarms it.
        idle_cnt   <= '0;
        idle_armed <= vote;
      end else if ((state == ST_IDLE) && rxs && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IW'(1);
        if ((idle_cnt == IDLE_FIRE) && idle_armed) begin
          rx_idle    <= 1'b1;
          idle_armed <= 1'b0;
        end
      end
    end
  end

endmodule
